// File: rtl/interp_pkg.sv
// interp_pkg: shared widths, phase/state encodings and the unsigned saturation helper
// used by interp_out_serializer and interp_sat.
package interp_pkg;
   localparam int DATA_WIDTH = 8;
   localparam int N_POS = 9;

   typedef enum logic [1:0] {PH_UP = 2'd0, PH_MID = 2'd1, PH_DOWN = 2'd2} phase_t;
   typedef enum logic {IDLE, SHIFT} state_t;

   // x carries an in_width-bit signed value; bits above in_width are ignored.
   function automatic logic [DATA_WIDTH:0] sat_u(input logic signed [31:0] x, input int in_width);
      logic signed [31:0] v;
      v = (x <<< (32 - in_width)) >>> (32 - in_width);
      return v < 0 ? {1'b1, {DATA_WIDTH{1'b0}}}
           : v > (2 ** DATA_WIDTH) - 1 ? {1'b1, {DATA_WIDTH{1'b1}}}
           : {1'b0, v[DATA_WIDTH-1:0]};
   endfunction
endpackage

// File: rtl/interp_sat.sv
// interp_sat: clips one signed filter result to the unsigned output sample range.
module interp_sat
   import interp_pkg::*;
#(
   parameter int IW = DATA_WIDTH + 3
) (
   input  logic signed [IW-1:0]    x,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    sat
);
   assign {sat, data} = sat_u(32'(x), IW);
endmodule

// File: rtl/interp_out_serializer.sv
// interp_out_serializer: streams a frame of UP/MID/DOWN filter results as saturated samples.
// Define INTERP_SER_PINGPONG_EN to add a shadow frame for gapless back-to-back frames.
module interp_out_serializer #(
   parameter int DATA_WIDTH = interp_pkg::DATA_WIDTH,
   parameter int N_POS      = interp_pkg::N_POS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [N_POS*(DATA_WIDTH+2)-1:0] in_up,
   input  logic [N_POS*(DATA_WIDTH+3)-1:0] in_mid,
   input  logic [N_POS*(DATA_WIDTH+2)-1:0] in_down,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_sat,
   output logic                           out_last
);
   import interp_pkg::*;
   localparam int UW = DATA_WIDTH + 2;
   localparam int MW = DATA_WIDTH + 3;
   localparam int PW = $clog2(N_POS);

   state_t state, state_n;
   phase_t phase, sel_ph;
   logic [PW-1:0] pos, sel_pos;
   logic [N_POS*UW-1:0] up_r, down_r, f_up, f_down;
   logic [N_POS*MW-1:0] mid_r, f_mid;
   logic signed [UW-1:0] up_e, down_e;
   logic signed [MW-1:0] mid_e, elem;
   logic [DATA_WIDTH-1:0] sat_data;
   logic sat_flag, acc, hs, at_end, last_hs, start, drain, load;

   assign acc = in_valid && in_ready;
   assign hs = out_valid && out_ready;
   assign at_end = pos == PW'(N_POS - 1) && phase == PH_DOWN;
   assign last_hs = state == SHIFT && hs && at_end;

`ifdef INTERP_SER_PINGPONG_EN
   logic [N_POS*UW-1:0] sh_up, sh_down;
   logic [N_POS*MW-1:0] sh_mid;
   logic shadow_full, load_sh;
   assign in_ready = !shadow_full;
   assign drain = last_hs && shadow_full;
   // A frame offered exactly on the final handshake with an empty shadow goes straight to active.
   assign start = acc && (state == IDLE || (last_hs && !shadow_full));
   assign load_sh = acc && !start;
   assign f_up = drain ? sh_up : start ? in_up : up_r;
   assign f_mid = drain ? sh_mid : start ? in_mid : mid_r;
   assign f_down = drain ? sh_down : start ? in_down : down_r;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         shadow_full <= 1'b0;
         sh_up <= '0;
         sh_mid <= '0;
         sh_down <= '0;
      end else begin
         shadow_full <= load_sh || (shadow_full && !drain);
         if (load_sh) begin
            sh_up <= in_up;
            sh_mid <= in_mid;
            sh_down <= in_down;
         end
      end
`else
   assign in_ready = state == IDLE;
   assign drain = 1'b0;
   assign start = acc;
   assign f_up = start ? in_up : up_r;
   assign f_mid = start ? in_mid : mid_r;
   assign f_down = start ? in_down : down_r;
`endif

   // pos/phase name the element on out_*; the mux looks one element ahead of it.
   assign sel_pos = (start || drain) ? '0 : phase == PH_DOWN ? pos + 1'b1 : pos;
   assign sel_ph = (start || drain) ? PH_UP : phase == PH_DOWN ? PH_UP : phase_t'(phase + 2'd1);
   assign up_e = f_up[int'(sel_pos)*UW +: UW];
   assign mid_e = f_mid[int'(sel_pos)*MW +: MW];
   assign down_e = f_down[int'(sel_pos)*UW +: UW];
   assign elem = sel_ph == PH_UP ? MW'(up_e) : sel_ph == PH_MID ? mid_e : MW'(down_e);
   assign load = start || drain || (state == SHIFT && hs && !at_end);

   interp_sat #(.IW(MW)) u_sat (.x(elem), .data(sat_data), .sat(sat_flag));

   always_comb begin
      state_n = state;
      if (state == IDLE && acc) state_n = SHIFT;
      else if (last_hs && !load) state_n = IDLE;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pos <= '0;
         phase <= PH_UP;
         up_r <= '0;
         mid_r <= '0;
         down_r <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_sat <= 1'b0;
         out_last <= 1'b0;
      end else begin
         if (start || drain) begin
            up_r <= f_up;
            mid_r <= f_mid;
            down_r <= f_down;
         end
         if (load) begin
            pos <= sel_pos;
            phase <= sel_ph;
            out_data <= sat_data;
            out_sat <= sat_flag;
            out_last <= sel_pos == PW'(N_POS - 1) && sel_ph == PH_DOWN;
         end else if (hs) out_last <= 1'b0;
         out_valid <= load || (out_valid && !hs);
      end
endmodule

// File: tb/tb_interp_out_serializer.sv
// tb_interp_out_serializer: directed/random frames checked against a queue-based beat model.
module tb_interp_out_serializer;
   localparam int DW = 8, NP = 9, UW = DW + 2, MW = DW + 3;
`ifdef INTERP_SER_PINGPONG_EN
   localparam int EXP_GAP = 0;
`else
   localparam int EXP_GAP = 2;
`endif

   typedef struct {int d; bit s; bit l;} beat_t;

   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, out_sat, out_last;
   logic [NP*UW-1:0] in_up = '0, in_down = '0;
   logic [NP*MW-1:0] in_mid = '0;
   logic [DW-1:0] out_data;
   int total = 0, bad = 0, gaps = 0;
   int up_v[NP], mid_v[NP], down_v[NP];
   bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   beat_t q[$];

   interp_out_serializer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_up(in_up), .in_mid(in_mid), .in_down(in_down),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_sat(out_sat), .out_last(out_last)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input int v, input bit l);
      beat_t b;
      b.d = v < 0 ? 0 : v > 255 ? 255 : v;
      b.s = v < 0 || v > 255;
      b.l = l;
      return b;
   endfunction

   // kind 0: random, 1: ramp 0/100/200+i, 2: random with boundary values at position 0
   task automatic make_frame(input int kind);
      for (int i = 0; i < NP; i++) begin
         up_v[i] = kind == 1 ? i : int'($urandom_range(383)) - 64;
         mid_v[i] = kind == 1 ? 100 + i : int'($urandom_range(1023)) - 256;
         down_v[i] = kind == 1 ? 200 + i : int'($urandom_range(383)) - 64;
      end
      if (kind == 2) begin
         up_v[0] = -5;
         mid_v[0] = 600;
         down_v[0] = 255;
      end
      for (int i = 0; i < NP; i++) begin
         in_up[i*UW +: UW] = UW'(up_v[i]);
         in_mid[i*MW +: MW] = MW'(mid_v[i]);
         in_down[i*UW +: UW] = UW'(down_v[i]);
      end
   endtask

   task automatic push_frame();
      for (int i = 0; i < NP; i++) begin
         q.push_back(mk(up_v[i], 1'b0));
         q.push_back(mk(mid_v[i], 1'b0));
         q.push_back(mk(down_v[i], i == NP - 1));
      end
   endtask

   // rmode 0: always ready, 1: fixed 1,0,0,1,0,1 pattern, 2: random
   task automatic run(input int nf, input int kind, input int rmode, input int stop_at, input int exp_gap);
      int sent = 0, beats = 0, guard = 0, k = 0;
      bit stall = 0, lat = 0, took = 0;
      logic [DW+1:0] held = '0;
      beat_t b;
      gaps = 0;
      make_frame(kind);
      while ((sent < nf || q.size() > 0) && guard < 3000 && !(stop_at > 0 && beats >= stop_at)) begin
         if (lat) chk("latency", out_valid, 1);
         if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {out_data, out_sat, out_last}, held);
         end
         in_valid = sent < nf;
         out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? pat[k % 6] : 1'($urandom_range(1));
         k++;
         if (!out_valid && beats > 0) gaps++;
         stall = out_valid && !out_ready;
         held = {out_data, out_sat, out_last};
         if (out_valid && out_ready) begin
            if (q.size() > 0) b = q.pop_front();
            else b = '{-1, 1'b0, 1'b0};
            chk("data", out_data, b.d);
            chk("sat", out_sat, b.s);
            chk("last", out_last, b.l);
            beats++;
         end
         lat = in_valid && in_ready && !out_valid;
         took = in_valid && in_ready;
         if (took) begin
            push_frame();
            sent++;
         end
         @(posedge clk);
         #1;
         if (took && sent < nf) make_frame(kind);
         guard++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      if (stop_at == 0) begin
         chk("sent", sent, nf);
         chk("drained", q.size(), 0);
         if (exp_gap >= 0) chk("gaps", gaps, exp_gap);
      end
   endtask

   initial begin
      int vcount;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_data", out_data, 0);
      chk("rst_sat", out_sat, 0);
      chk("rst_last", out_last, 0);
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_data", out_data, 0);
      run(1, 1, 0, 0, 0);
      run(1, 2, 0, 0, 0);
      run(1, 0, 1, 0, 0);
      run(3, 0, 0, 0, EXP_GAP);
      run(2, 0, 2, 0, -1);
      run(2, 0, 0, 10, -1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_last", out_last, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      run(1, 1, 0, 0, 0);
      vcount = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) vcount++;
      end
      chk("idle_after_reset_frame", vcount, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
